uart_rx_core: RTL and testbench

- UART receiver, the counterpart of the existing transmit path.
- Generates its own 16x-oversampling tick enable from the shared 16-bit baud divisor (brd).
- Synchronises and deserialises the asynchronous rx line: 8N1, LSB first.
- Presents each byte on a valid/ready interface to the LSU-side MMIO logic, with frame-error and overrun status pulses.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_tick_gen.sv | 29 ++
 rtl/uart_rx_core.sv | 145 ++++++++++++++
 tb/tb_uart_rx_core.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling points and the
// baud-divisor limit helper used by the tick generators.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } rx_state_t;

    localparam int unsigned OVERSAMPLE  = 16;
    localparam logic [3:0]  MID_SAMPLE  = 4'd7;
    localparam logic [3:0]  LAST_SAMPLE = 4'(OVERSAMPLE - 1);

    // A divisor of zero behaves like one: a tick on every cycle.
    function automatic logic [15:0] brd_limit(input logic [15:0] brd);
        return (brd == 16'd0) ? 16'd0 : brd - 16'd1;
    endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Oversampling tick enable: one-cycle pulse every brd clk cycles, shared with the
// transmit side. A new divisor is picked up only when the counter wraps.
module uart_rx_tick_gen
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] brd,
    output logic        tick
);

    logic [15:0] div_cnt;
    logic [15:0] div_lim;

    assign tick = (div_cnt == div_lim);

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= 16'd0;
            div_lim <= brd_limit(brd);
        end else if (tick) begin
            div_cnt <= 16'd0;
            div_lim <= brd_limit(brd);
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 16x oversampled, 8N1 LSB first, valid/ready byte output.
// Define UART_RX_PARITY_EN to add a parity bit (parity_odd / parity_err ports).
//
// state  | meaning
// IDLE   | waiting for a 1->0 edge on the synchronised line
// START  | counting to mid start bit; line high there is a false start
// DATA   | sampling data bits at sample count 15, LSB first
// PARITY | sampling the parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling the stop bit, then deliver or flag frame error
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8
)
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [15:0]          brd,
    input  logic                 rx_in,
    input  logic                 rx_ready,
`ifdef UART_RX_PARITY_EN
    input  logic                 parity_odd,
    output logic                 parity_err,
`endif
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 rx_busy
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    rx_state_t            state, state_nx;
    logic                 tick;
    logic                 rx_meta, rx_sync, rx_prev;
    logic [3:0]           samp_cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 mid_pt, end_pt;
    logic                 shift_en, stop_smp;

    uart_rx_tick_gen u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .brd   (brd),
        .tick  (tick)
    );

    assign mid_pt = tick && (samp_cnt == MID_SAMPLE);
    assign end_pt = tick && (samp_cnt == LAST_SAMPLE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (rx_prev && !rx_sync) state_nx = START;
            START: if (mid_pt) state_nx = rx_sync ? IDLE : DATA;
            DATA: begin
                if (end_pt && (bit_cnt == LAST_BIT)) begin
`ifdef UART_RX_PARITY_EN
                    state_nx = PARITY;
`else
                    state_nx = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (end_pt) state_nx = STOP;
`endif
            STOP:  if (end_pt) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        shift_en = (state == DATA) && end_pt;
        stop_smp = (state == STOP) && end_pt;
        rx_busy  = (state != IDLE);
    end

    // Sample counter restarts on every state change so each state counts from 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            samp_cnt <= 4'd0;
            bit_cnt  <= 3'd0;
            shreg    <= '0;
        end else begin
            rx_meta <= rx_in;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            if (state_nx != state) samp_cnt <= 4'd0;
            else if (tick)         samp_cnt <= samp_cnt + 4'd1;
            if (state == IDLE)     bit_cnt <= 3'd0;
            else if (shift_en)     bit_cnt <= bit_cnt + 3'd1;
            if (shift_en)          shreg <= {rx_sync, shreg[DATA_BITS-1:1]};
        end
    end

    // A completed byte is dropped, not queued, when the holding register is still full.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_smp && !rx_sync;
            overrun   <= stop_smp && rx_sync && rx_valid && !rx_ready;
            if (stop_smp && rx_sync && (!rx_valid || rx_ready)) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_acc, par_bad, par_smp;

    assign par_smp = (state == PARITY) && end_pt;

    always_ff @(posedge clk) begin
        if (reset) begin
            par_acc    <= 1'b0;
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (state == IDLE) par_acc <= 1'b0;
            else if (shift_en) par_acc <= par_acc ^ rx_sync;
            if (par_smp)       par_bad <= rx_sync != (par_acc ^ parity_odd);
            parity_err <= stop_smp && par_bad;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed frames at brd=4, scoreboard
// queues filled by the stimulus and drained by an independent output monitor.
module tb_uart_rx_core;

    localparam int BIT_CLKS = 64;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] brd = 16'd4;
    logic        rx_in = 1'b1;
    logic        rx_ready = 1'b1;
    logic [7:0]  rx_data;
    logic        rx_valid, frame_err, overrun, rx_busy;
`ifdef UART_RX_PARITY_EN
    logic        parity_odd = 1'b0;
    logic        parity_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] data_q[$];
    logic [7:0] ovr_q[$];
    bit         ferr_q[$];
    bit         perr_q[$];

    uart_rx_core #(.DATA_BITS(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .brd        (brd),
        .rx_in      (rx_in),
        .rx_ready   (rx_ready),
`ifdef UART_RX_PARITY_EN
        .parity_odd (parity_odd),
        .parity_err (parity_err),
`endif
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .rx_busy    (rx_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #600us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: unexpected event, rx_data=%0h, nothing expected", name, act);
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard queues.
    logic       prev_valid = 1'b0, prev_take = 1'b0, prev_ferr = 1'b0, prev_ovr = 1'b0;
    logic [7:0] prev_data = 8'h00;
`ifdef UART_RX_PARITY_EN
    logic       prev_perr = 1'b0;
`endif

    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid && rx_ready) begin
                if (data_q.size() == 0) unexpected("rx_byte", rx_data);
                else check("rx_byte", rx_data, data_q.pop_front());
            end
            if (prev_valid && !prev_take && rx_valid)
                check("rx_data_stable", rx_data, prev_data);
            if (frame_err) begin
                check("frame_err_width", prev_ferr, 0);
                if (ferr_q.size() == 0) unexpected("frame_err", rx_data);
                else void'(ferr_q.pop_front());
            end
            if (overrun) begin
                check("overrun_width", prev_ovr, 0);
                if (ovr_q.size() == 0) unexpected("overrun", rx_data);
                else check("overrun_held_data", rx_data, ovr_q.pop_front());
            end
`ifdef UART_RX_PARITY_EN
            if (parity_err) begin
                check("parity_err_width", prev_perr, 0);
                if (perr_q.size() == 0) unexpected("parity_err", rx_data);
                else void'(perr_q.pop_front());
            end
            prev_perr = parity_err;
`endif
        end
        prev_valid = rx_valid && !reset;
        prev_take  = rx_valid && rx_ready;
        prev_data  = rx_data;
        prev_ferr  = frame_err;
        prev_ovr   = overrun;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        wait_clks(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (PAR_EN) send_bit(par_b);
        send_bit(stop_b);
        send_bit(1'b1);
    endtask

    task automatic expect_byte(input logic [7:0] d);
        data_q.push_back(d);
        send_frame(d, 1'b1, ^d);
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((data_q.size() + ovr_q.size() + ferr_q.size() + perr_q.size()) != 0 && k < 2000) begin
            wait_clks(1);
            k++;
        end
        check(name, data_q.size() + ovr_q.size() + ferr_q.size() + perr_q.size(), 0);
        data_q.delete(); ovr_q.delete(); ferr_q.delete(); perr_q.delete();
    endtask

    initial begin
        wait_clks(3);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_overrun", overrun, 0);
        check("reset_rx_busy", rx_busy, 0);
        reset = 1'b0;
        wait_clks(2 * BIT_CLKS);

        expect_byte(8'h00);
        expect_byte(8'hFF);
        expect_byte(8'hA5);
        drain("drain_basic");

        rx_in = 1'b0;
        wait_clks(12);
        rx_in = 1'b1;
        wait_clks(2 * BIT_CLKS);
        check("false_start_busy", rx_busy, 0);
        check("false_start_valid", rx_valid, 0);
        expect_byte(8'h3C);
        drain("drain_false_start");

        ferr_q.push_back(1'b1);
        send_frame(8'h55, 1'b0, ^8'h55);
        check("bad_stop_valid", rx_valid, 0);
        drain("drain_bad_stop");

        ferr_q.push_back(1'b1);
        rx_in = 1'b0;
        wait_clks(12 * BIT_CLKS);
        check("break_idle", rx_busy, 0);
        rx_in = 1'b1;
        wait_clks(2 * BIT_CLKS);
        drain("drain_break");

        rx_ready = 1'b0;
        data_q.push_back(8'h11);
        ovr_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, ^8'h11);
        send_frame(8'h22, 1'b1, ^8'h22);
        check("overrun_valid_held", rx_valid, 1);
        check("overrun_data_held", rx_data, 8'h11);
        rx_ready = 1'b1;
        wait_clks(1);
        check("overrun_valid_drop", rx_valid, 0);
        drain("drain_overrun");

        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        check("mid_frame_busy", rx_busy, 1);
        rx_in = 1'b1;
        reset = 1'b1;
        wait_clks(1);
        reset = 1'b0;
        check("midreset_rx_data", rx_data, 8'h00);
        check("midreset_rx_valid", rx_valid, 0);
        check("midreset_frame_err", frame_err, 0);
        check("midreset_overrun", overrun, 0);
        check("midreset_rx_busy", rx_busy, 0);
        wait_clks(2 * BIT_CLKS);
        expect_byte(8'h42);
        drain("drain_midreset");

`ifdef UART_RX_PARITY_EN
        parity_odd = 1'b0;
        data_q.push_back(8'h07);
        perr_q.push_back(1'b1);
        send_frame(8'h07, 1'b1, 1'b0);
        drain("drain_parity_bad");
        data_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        drain("drain_parity_even_ok");
        parity_odd = 1'b1;
        data_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b0);
        drain("drain_parity_odd_ok");
`endif

        wait_clks(BIT_CLKS);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
